// File: rtl/sc_metadata_table_pkg.sv
// Shared constants for the score-controller note metadata table.
// Channel count, time width and default miss window.
package sc_pkg;
    localparam int NUM_NOTES = 37;
    localparam int TW = 16;
    localparam int NOTE_IDX_W = 6;
    localparam int LINK_W = 16;
    localparam logic [TW-1:0] MISS_WINDOW_DEF = 16'd150;
endpackage

// File: rtl/sc_metadata_table_chan.sv
// One note channel: 2-entry head/next buffer with pop, write and
// miss-window expiry.
module sc_meta_chan
    import sc_pkg::*;
#(
    parameter logic [TW-1:0] MISS_WINDOW = MISS_WINDOW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          pause,
    input  logic [TW-1:0] song_time,
    input  logic          req,
    input  logic          wr_en,
    input  logic [TW-1:0] wr_time,
    output logic          avail,
    output logic          full,
    output logic [TW-1:0] head,
    output logic          miss
);
    logic [1:0]    count;
    logic [TW-1:0] nxt;
    logic          expired;
    logic          pop;

    // 17-bit compare so head + window never wraps
    assign expired = !pause && (count != 2'd0) &&
                     ({1'b0, song_time} > ({1'b0, head} + {1'b0, MISS_WINDOW}));
    assign pop   = (count != 2'd0) && (req || expired);
    assign miss  = expired && !req;
    assign avail = (count != 2'd0);
    assign full  = (count == 2'd2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 2'd0;
            head  <= '0;
            nxt   <= '0;
        end else if (clear) begin
            count <= 2'd0;
            head  <= '0;
            nxt   <= '0;
        end else begin
            case ({pop, wr_en})
                2'b11: begin
                    if (count == 2'd1) begin
                        head <= wr_time;
                    end else begin
                        head <= nxt;
                        nxt  <= wr_time;
                    end
                end
                2'b10: begin
                    head  <= (count == 2'd2) ? nxt : '0;
                    nxt   <= '0;
                    count <= count - 2'd1;
                end
                2'b01: begin
                    if (count == 2'd0) begin
                        head  <= wr_time;
                        count <= 2'd1;
                    end else begin
                        nxt   <= wr_time;
                        count <= 2'd2;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/sc_metadata_table.sv
// Note metadata responder: per-channel head times for the matcher,
// chart-loader write port, and missed-note accounting.
module sc_metadata_table
    import sc_pkg::*;
#(
    parameter logic [TW-1:0] MISS_WINDOW = MISS_WINDOW_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pause,
    input  logic                      clear,
    input  logic [TW-1:0]             song_time,
    input  logic                      wr_valid,
    input  logic [NOTE_IDX_W-1:0]     wr_note,
    input  logic [TW-1:0]             wr_time,
    output logic                      wr_ready,
    output logic                      wr_err,
    input  logic [NUM_NOTES-1:0]      metadata_request,
    output logic [NUM_NOTES-1:0]      metadata_available,
    output logic [NUM_NOTES*LINK_W-1:0] metadata_link,
    output logic                      miss_pulse,
    output logic [15:0]               miss_count
);
    logic [NUM_NOTES-1:0] full;
    logic [NUM_NOTES-1:0] miss;
    logic [NUM_NOTES-1:0] wr_en;
    logic                 note_ok;
    logic                 sel_full;
    logic                 sel_req;
    logic [5:0]           pop_cnt;
    logic [16:0]          sum;

    assign note_ok = (wr_note < NOTE_IDX_W'(NUM_NOTES));

    always_comb begin
        sel_full = 1'b0;
        sel_req  = 1'b0;
        for (int i = 0; i < NUM_NOTES; i++) begin
            if (wr_note == NOTE_IDX_W'(i)) begin
                sel_full = full[i];
                sel_req  = metadata_request[i];
            end
        end
    end

    assign wr_ready = !rst && !clear && (!note_ok || !sel_full || sel_req);

    always_comb begin
        pop_cnt = 6'd0;
        for (int i = 0; i < NUM_NOTES; i++) begin
            pop_cnt = pop_cnt + {5'd0, miss[i]};
        end
    end

    assign sum = {1'b0, miss_count} + {11'd0, pop_cnt};

    genvar g;
    generate
        for (g = 0; g < NUM_NOTES; g++) begin : g_chan
            assign wr_en[g] = wr_valid && wr_ready && note_ok &&
                              (wr_note == NOTE_IDX_W'(g));
            sc_meta_chan #(.MISS_WINDOW(MISS_WINDOW)) u_chan (
                .clk       (clk),
                .rst       (rst),
                .clear     (clear),
                .pause     (pause),
                .song_time (song_time),
                .req       (metadata_request[g]),
                .wr_en     (wr_en[g]),
                .wr_time   (wr_time),
                .avail     (metadata_available[g]),
                .full      (full[g]),
                .head      (metadata_link[g*LINK_W +: LINK_W]),
                .miss      (miss[g])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miss_count <= 16'd0;
            miss_pulse <= 1'b0;
            wr_err     <= 1'b0;
        end else if (clear) begin
            miss_count <= 16'd0;
            miss_pulse <= 1'b0;
            wr_err     <= 1'b0;
        end else begin
            miss_count <= sum[16] ? 16'hFFFF : sum[15:0];
            miss_pulse <= (pop_cnt != 6'd0);
            wr_err     <= wr_valid && !note_ok;
        end
    end
endmodule

// File: tb/tb_sc_metadata_table.sv
// Directed self-checking bench for sc_metadata_table.
module tb_sc_metadata_table;
    logic         clk = 1'b0;
    logic         rst;
    logic         pause;
    logic         clear;
    logic [15:0]  song_time;
    logic         wr_valid;
    logic [5:0]   wr_note;
    logic [15:0]  wr_time;
    logic         wr_ready;
    logic         wr_err;
    logic [36:0]  metadata_request;
    logic [36:0]  metadata_available;
    logic [591:0] metadata_link;
    logic         miss_pulse;
    logic [15:0]  miss_count;

    int checks = 0;
    int fails = 0;

    sc_metadata_table dut (
        .clk                (clk),
        .rst                (rst),
        .pause              (pause),
        .clear              (clear),
        .song_time          (song_time),
        .wr_valid           (wr_valid),
        .wr_note            (wr_note),
        .wr_time            (wr_time),
        .wr_ready           (wr_ready),
        .wr_err             (wr_err),
        .metadata_request   (metadata_request),
        .metadata_available (metadata_available),
        .metadata_link      (metadata_link),
        .miss_pulse         (miss_pulse),
        .miss_count         (miss_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int n, input int t);
        wr_valid = 1'b1;
        wr_note  = 6'(n);
        wr_time  = 16'(t);
        tick();
        wr_valid = 1'b0;
    endtask

    function automatic logic [15:0] lnk(input int ch);
        return metadata_link[16*ch +: 16];
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        pause = 1'b0;
        clear = 1'b0;
        song_time = 16'd0;
        wr_valid = 1'b0;
        wr_note = 6'd0;
        wr_time = 16'd0;
        metadata_request = '0;
        #2;
        checks++;
        if (metadata_available !== 37'd0 || metadata_link !== '0) begin
            fails++;
            $display("FAIL reset_outputs avail=%h link_nonzero=%0d", metadata_available, |metadata_link);
        end
        checks++;
        if (wr_ready !== 1'b0 || miss_count !== 16'd0 || miss_pulse !== 1'b0 || wr_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctrl rdy=%b cnt=%h mp=%b err=%b want 0", wr_ready, miss_count, miss_pulse, wr_err);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fill_pop();
        wr(5, 1000);
        wr(5, 1200);
        checks++;
        if (metadata_available[5] !== 1'b1 || lnk(5) !== 16'd1000) begin
            fails++;
            $display("FAIL fill_head av=%b link=%0d want 1/1000", metadata_available[5], lnk(5));
        end
        metadata_request[5] = 1'b1;
        tick();
        metadata_request[5] = 1'b0;
        checks++;
        if (metadata_available[5] !== 1'b1 || lnk(5) !== 16'd1200) begin
            fails++;
            $display("FAIL pop_next av=%b link=%0d want 1/1200", metadata_available[5], lnk(5));
        end
        metadata_request[5] = 1'b1;
        tick();
        metadata_request[5] = 1'b0;
        checks++;
        if (metadata_available[5] !== 1'b0 || lnk(5) !== 16'd0) begin
            fails++;
            $display("FAIL pop_empty av=%b link=%0d want 0/0", metadata_available[5], lnk(5));
        end
        metadata_request[5] = 1'b1;
        tick();
        metadata_request[5] = 1'b0;
        checks++;
        if (metadata_available !== 37'd0) begin
            fails++;
            $display("FAIL pop_on_empty avail=%h want 0", metadata_available);
        end
    endtask

    task automatic test_full();
        wr(7, 500);
        wr(7, 600);
        wr_valid = 1'b1;
        wr_note = 6'd7;
        wr_time = 16'd900;
        #1;
        checks++;
        if (wr_ready !== 1'b0) begin
            fails++;
            $display("FAIL full_ready rdy=%b want 0", wr_ready);
        end
        tick();
        checks++;
        if (lnk(7) !== 16'd500) begin
            fails++;
            $display("FAIL full_hold link=%0d want 500", lnk(7));
        end
        metadata_request[7] = 1'b1;
        #1;
        checks++;
        if (wr_ready !== 1'b1) begin
            fails++;
            $display("FAIL full_ready_req rdy=%b want 1", wr_ready);
        end
        tick();
        wr_valid = 1'b0;
        checks++;
        if (lnk(7) !== 16'd600 || metadata_available[7] !== 1'b1) begin
            fails++;
            $display("FAIL full_swap link=%0d av=%b want 600/1", lnk(7), metadata_available[7]);
        end
        tick();
        metadata_request[7] = 1'b0;
        checks++;
        if (lnk(7) !== 16'd900 || metadata_available[7] !== 1'b1) begin
            fails++;
            $display("FAIL full_second link=%0d av=%b want 900/1", lnk(7), metadata_available[7]);
        end
        metadata_request[7] = 1'b1;
        tick();
        metadata_request[7] = 1'b0;
        checks++;
        if (metadata_available[7] !== 1'b0) begin
            fails++;
            $display("FAIL full_drain av=%b want 0", metadata_available[7]);
        end
    endtask

    task automatic test_expiry();
        wr(3, 1000);
        song_time = 16'd1150;
        tick();
        checks++;
        if (metadata_available[3] !== 1'b1 || miss_pulse !== 1'b0 || miss_count !== 16'd0) begin
            fails++;
            $display("FAIL exp_edge av=%b mp=%b cnt=%0d want 1/0/0", metadata_available[3], miss_pulse, miss_count);
        end
        song_time = 16'd1151;
        tick();
        checks++;
        if (metadata_available[3] !== 1'b0 || miss_pulse !== 1'b1 || miss_count !== 16'd1) begin
            fails++;
            $display("FAIL exp_hit av=%b mp=%b cnt=%0d want 0/1/1", metadata_available[3], miss_pulse, miss_count);
        end
        tick();
        checks++;
        if (miss_pulse !== 1'b0) begin
            fails++;
            $display("FAIL exp_pulse_len mp=%b want 0", miss_pulse);
        end
        song_time = 16'd0;
        wr(3, 1000);
        pause = 1'b1;
        song_time = 16'd2000;
        tick();
        tick();
        checks++;
        if (metadata_available[3] !== 1'b1 || miss_count !== 16'd1 || miss_pulse !== 1'b0) begin
            fails++;
            $display("FAIL exp_pause av=%b cnt=%0d mp=%b want 1/1/0", metadata_available[3], miss_count, miss_pulse);
        end
        pause = 1'b0;
        tick();
        checks++;
        if (metadata_available[3] !== 1'b0 || miss_count !== 16'd2) begin
            fails++;
            $display("FAIL exp_unpause av=%b cnt=%0d want 0/2", metadata_available[3], miss_count);
        end
        song_time = 16'd0;
    endtask

    task automatic test_multi();
        wr(0, 100);
        wr(36, 100);
        song_time = 16'd300;
        metadata_request[0] = 1'b1;
        tick();
        metadata_request[0] = 1'b0;
        checks++;
        if (miss_count !== 16'd3 || miss_pulse !== 1'b1) begin
            fails++;
            $display("FAIL multi_count cnt=%0d mp=%b want 3/1", miss_count, miss_pulse);
        end
        checks++;
        if (metadata_available[0] !== 1'b0 || metadata_available[36] !== 1'b0) begin
            fails++;
            $display("FAIL multi_pop av0=%b av36=%b want 0/0", metadata_available[0], metadata_available[36]);
        end
        song_time = 16'd0;
    endtask

    task automatic test_invalid();
        wr_valid = 1'b1;
        wr_note = 6'd40;
        wr_time = 16'd77;
        #1;
        checks++;
        if (wr_ready !== 1'b1) begin
            fails++;
            $display("FAIL inv_ready rdy=%b want 1", wr_ready);
        end
        tick();
        wr_valid = 1'b0;
        checks++;
        if (wr_err !== 1'b1 || metadata_available !== 37'd0 || metadata_link !== '0) begin
            fails++;
            $display("FAIL inv_err err=%b avail=%h want 1/0", wr_err, metadata_available);
        end
        tick();
        checks++;
        if (wr_err !== 1'b0) begin
            fails++;
            $display("FAIL inv_pulse err=%b want 0", wr_err);
        end
    endtask

    task automatic test_clear();
        wr(9, 50);
        clear = 1'b1;
        wr_valid = 1'b1;
        wr_note = 6'd10;
        wr_time = 16'd60;
        #1;
        checks++;
        if (wr_ready !== 1'b0) begin
            fails++;
            $display("FAIL clr_ready rdy=%b want 0", wr_ready);
        end
        tick();
        clear = 1'b0;
        wr_valid = 1'b0;
        checks++;
        if (metadata_available !== 37'd0 || metadata_link !== '0 || miss_count !== 16'd0) begin
            fails++;
            $display("FAIL clr_state avail=%h cnt=%0d want 0/0", metadata_available, miss_count);
        end
    endtask

    task automatic test_saturate();
        song_time = 16'd1000;
        wr_valid = 1'b1;
        wr_note = 6'd1;
        wr_time = 16'd0;
        for (int i = 0; i < 65536; i++) @(posedge clk);
        #1;
        checks++;
        if (miss_count !== 16'hFFFF) begin
            fails++;
            $display("FAIL sat_reach cnt=%h want ffff", miss_count);
        end
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (miss_count !== 16'hFFFF || miss_pulse !== 1'b1) begin
            fails++;
            $display("FAIL sat_hold cnt=%h mp=%b want ffff/1", miss_count, miss_pulse);
        end
        wr_valid = 1'b0;
        tick();
        song_time = 16'd0;
        tick();
    endtask

    task automatic test_reset_mid();
        wr(5, 10);
        wr(5, 20);
        checks++;
        if (metadata_available[5] !== 1'b1 || miss_count !== 16'hFFFF) begin
            fails++;
            $display("FAIL rmid_pre av=%b cnt=%h want 1/ffff", metadata_available[5], miss_count);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (metadata_available !== 37'd0 || metadata_link !== '0 || miss_count !== 16'd0) begin
            fails++;
            $display("FAIL rmid_async avail=%h cnt=%h want 0/0", metadata_available, miss_count);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_fill_pop();
        test_full();
        test_expiry();
        test_multi();
        test_invalid();
        test_clear();
        test_saturate();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end
endmodule

// File: doc/sc_metadata_table.md
Name: sc_metadata_table

Overview:
- Responder side of the note-metadata handshake used by the score controller's note matcher.
- Buffers upcoming note-on times per note channel (37 channels), loaded from the chart loader.
- Presents the oldest pending time on metadata_link / metadata_available, and pops it when the matcher pulses metadata_request.
- Auto-expires notes the player missed, and counts them for the AV/score path.

Parameters:
- NUM_NOTES, 37, number of note channels (fixed by NDATA width).
- TW, 16, song-time width in ms.
- MISS_WINDOW, 16'd150, ms after a note's time before it is auto-dropped as missed.

Ports:
- clk  in  1  100 MHz system clock.
- rst  in  1  asynchronous, active-high reset.
- pause  in  1  game paused; freezes expiry.
- clear  in  1  synchronous flush of all channels (song restart).
- song_time  in  16  current song time, ms.
- wr_valid  in  1  chart loader offers an entry.
- wr_note  in  6  target channel, 0..36.
- wr_time  in  16  note-on time.
- wr_ready  out  1  entry accepted this cycle when wr_valid && wr_ready.
- wr_err  out  1  one-cycle pulse: wr_note >= 37, entry discarded.
- metadata_request  in  37  per-channel pop pulse from the matcher.
- metadata_available  out  37  bit i high when channel i head is valid.
- metadata_link  out  592  channel i head time at bits [16*i+15:16*i].
- miss_pulse  out  1  one-cycle pulse when any note expires this cycle.
- miss_count  out  16  total expired notes, saturating at 16'hFFFF.

Behaviour:
- Reset is asynchronous and active-high. All outputs are 0, all channel counts are 0, and miss_count is 0. wr_ready is 0 during reset and 1 afterwards when its rule allows.
- Per-channel storage is a 2-entry buffer: head (H) and next (N), plus a count of 0..2.
  - metadata_available[i] = (count_i != 0).
  - metadata_link slice = H_i, registered. The slice is 0 when the channel is empty.
- Pop:
  - When metadata_request[i] is high and count_i > 0, N moves to H on the next edge and the count decrements.
  - A request on an empty channel is ignored.
  - The matcher sees the new head 1 cycle after its request.
- Write:
  - wr_ready = (wr_note >= 37) || (count[wr_note] < 2) || metadata_request[wr_note]. This is combinational on wr_note.
  - On an accepted write, the entry goes to H if the channel is empty (or becomes empty via a same-cycle pop). Otherwise it goes to N.
  - Same-cycle pop and write on a full channel: H <= N, N <= wr_time, and the count stays at 2.
  - Invalid note: the entry is consumed (wr_ready = 1), dropped, and wr_err pulses.
- Expiry:
  - Applies when pause = 0 and count_i > 0.
  - Channel i expires when {1'b0,song_time} > {1'b0,H_i} + MISS_WINDOW, computed 17 bits wide with no wrap.
  - An expiry pops the channel exactly like a request.
- Expiry arbitration:
  - At most one pop per channel per cycle. If a request and an expiry coincide, the request wins and no miss is counted.
  - Several channels may expire in the same cycle. miss_count adds the popcount of expired channels, saturating, and miss_pulse = (popcount != 0).
- Pause: pops and writes still operate; only expiry is inhibited.
- clear: counts go to 0 and outputs go to the empty state on the next edge. miss_count is also zeroed. Writes and requests presented in the same cycle as clear are ignored, and wr_ready = 0 while clear is high.
- Ordering: the loader must write each channel in non-decreasing time. The block does not sort.

Decomposition:
- Shared package sc_pkg holds:
  - NUM_NOTES, TW, NOTE_IDX_W = 6.
  - The metadata_link slice helper constant (16).
  - MISS_WINDOW default.
- One natural sub-module: sc_meta_chan, the 2-entry buffer for one channel with expiry compare, instantiated 37 times via generate. The top level handles write decode, wr_ready/wr_err, popcount, and the miss counter.

Test Plan:
- Reset mid-operation: with ch 5 holding 2 entries, assert rst -> metadata_available = 0, metadata_link = 0, and miss_count = 0 immediately, with no clock edge needed.
- Write (5, 1000) then (5, 1200); pulse request[5] -> link[5] reads 1000, then 1200 one cycle after the request, then available[5] = 0 after a second request.
- Fill ch 7 with 2 entries; wr_valid (7, 900) with no request -> wr_ready = 0. Same write with request[7] high -> accepted, and the buffer becomes {old N, 900}.
- Ch 3 head = 1000, MISS_WINDOW = 150:
  - song_time = 1150 -> no expiry.
  - song_time = 1151 -> miss_pulse = 1, miss_count = 1, ch 3 pops.
  - Repeat with pause = 1 -> no expiry.
- Ch 0 and ch 36 both expire in the same cycle while request[0] is high -> miss_count increases by 1 only, and both channels pop.
- Write with wr_note = 40 -> wr_ready = 1, wr_err pulses, and no channel changes. Preload miss_count = 16'hFFFF, then expire a note -> miss_count stays 16'hFFFF.
